// File: rtl/lm32_interrupt_vec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lm32_interrupt_vec                                            |
// | Purpose  : LM32 interrupt controller with IE/IM/IP CSRs, per-channel     |
// |            edge/level mode (IEDGE) and a registered priority-encoded     |
// |            pending vector (IVEC).                                        |
// | Options  : CFG_INT_SYNC_EN - 2-flop synchroniser on interrupt_n.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lm32_interrupt_vec #(
  parameter int         INTERRUPTS = 32,
  parameter logic [4:0] CSR_IE     = 5'h00,
  parameter logic [4:0] CSR_IM     = 5'h01,
  parameter logic [4:0] CSR_IP     = 5'h02,
  parameter logic [4:0] CSR_IEDGE  = 5'h1A,
  parameter logic [4:0] CSR_IVEC   = 5'h1B
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INTERRUPTS-1:0] interrupt_n,
  input  logic                  stall_x,
  input  logic                  non_debug_exception,
  input  logic                  debug_exception,
  input  logic                  eret_q_x,
  input  logic                  bret_q_x,
  input  logic [4:0]            csr,
  input  logic [31:0]           csr_write_data,
  input  logic                  csr_write_enable,
  output logic                  interrupt_exception,
  output logic                  irq_valid,
  output logic [4:0]            irq_id,
  output logic [31:0]           csr_read_data
);

  logic                  ie_q, eie_q, bie_q;
  logic                  ie_d, eie_d, bie_d;
  logic [INTERRUPTS-1:0] im_q, im_d;
  logic [INTERRUPTS-1:0] ip_q, ip_d;
  logic [INTERRUPTS-1:0] iedge_q, iedge_d;
  logic [INTERRUPTS-1:0] prev_n_q;
  logic                  irq_valid_q, irq_valid_d;
  logic [4:0]            irq_id_q, irq_id_d;

  logic [INTERRUPTS-1:0] pins_w;
  logic [INTERRUPTS-1:0] set_w;
  logic [INTERRUPTS-1:0] ip_clr_w;
  logic [INTERRUPTS-1:0] pend_w;
  logic [INTERRUPTS-1:0] wd_w;

`ifdef CFG_INT_SYNC_EN
  logic [INTERRUPTS-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser for the asynchronous pins; idles deasserted (high).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= interrupt_n;
      sync2_q <= sync1_q;
    end
  end

  assign pins_w = sync2_q;
`else
  assign pins_w = interrupt_n;
`endif

  assign wd_w   = csr_write_data[INTERRUPTS-1:0];
  assign pend_w = ip_q & im_q;

  // Edge channels set on a high-to-low transition, level channels while low.
  assign set_w = (iedge_q & prev_n_q & ~pins_w) | (~iedge_q & ~pins_w);

  assign interrupt_exception = ie_q & (|pend_w);
  assign irq_valid           = irq_valid_q;
  assign irq_id              = irq_id_q;

  // Enable nesting, eret/bret restore and CSR writes; one action per cycle.
  always_comb begin
    ie_d     = ie_q;
    eie_d    = eie_q;
    bie_d    = bie_q;
    im_d     = im_q;
    iedge_d  = iedge_q;
    ip_clr_w = '0;
    if (non_debug_exception) begin
      eie_d = ie_q;
      ie_d  = 1'b0;
    end else if (debug_exception) begin
      bie_d = ie_q;
      ie_d  = 1'b0;
    end else if (!stall_x) begin
      if (eret_q_x) begin
        ie_d = eie_q;
      end else if (bret_q_x) begin
        ie_d = bie_q;
      end else if (csr_write_enable) begin
        if (csr == CSR_IE) begin
          ie_d  = csr_write_data[0];
          eie_d = csr_write_data[1];
          bie_d = csr_write_data[2];
        end else if (csr == CSR_IM) begin
          im_d = wd_w;
        end else if (csr == CSR_IP) begin
          ip_clr_w = wd_w;
        end else if (csr == CSR_IEDGE) begin
          iedge_d = wd_w;
        end
      end
    end
    // A new set term wins over a simultaneous software clear.
    ip_d = (ip_q & ~ip_clr_w) | set_w;
  end

  // Lowest-index unmasked pending channel; scanning downward lets index 0 win.
  always_comb begin
    irq_valid_d = |pend_w;
    irq_id_d    = 5'd0;
    for (int i = INTERRUPTS - 1; i >= 0; i--) begin
      if (pend_w[i]) begin
        irq_id_d = 5'(i);
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ie_q        <= 1'b0;
      eie_q       <= 1'b0;
      bie_q       <= 1'b0;
      im_q        <= '0;
      ip_q        <= '0;
      iedge_q     <= '0;
      prev_n_q    <= '1;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 5'd0;
    end else begin
      ie_q        <= ie_d;
      eie_q       <= eie_d;
      bie_q       <= bie_d;
      im_q        <= im_d;
      ip_q        <= ip_d;
      iedge_q     <= iedge_d;
      prev_n_q    <= pins_w;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
    end
  end

  // CSR read mux; narrow registers are zero-extended.
  always_comb begin
    csr_read_data = 32'd0;
    if (csr == CSR_IE) begin
      csr_read_data[2:0] = {bie_q, eie_q, ie_q};
    end else if (csr == CSR_IM) begin
      csr_read_data[INTERRUPTS-1:0] = im_q;
    end else if (csr == CSR_IP) begin
      csr_read_data[INTERRUPTS-1:0] = ip_q;
    end else if (csr == CSR_IEDGE) begin
      csr_read_data[INTERRUPTS-1:0] = iedge_q;
    end else if (csr == CSR_IVEC) begin
      csr_read_data[31]  = irq_valid_q;
      csr_read_data[4:0] = irq_id_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lm32_interrupt_vec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lm32_interrupt_vec                                         |
// | Purpose  : Self-checking bench for lm32_interrupt_vec; directed cases    |
// |            plus randomized traffic against a behavioural model.          |
// | Options  : CFG_INT_SYNC_EN shifts pin latency by SYNC cycles.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lm32_interrupt_vec;

  localparam int N = 24;
`ifdef CFG_INT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam logic [4:0]  A_IE    = 5'h00;
  localparam logic [4:0]  A_IM    = 5'h01;
  localparam logic [4:0]  A_IP    = 5'h02;
  localparam logic [4:0]  A_IEDGE = 5'h1A;
  localparam logic [4:0]  A_IVEC  = 5'h1B;
  localparam logic [31:0] MASK    = 32'((64'd1 << N) - 64'd1);

  logic          clk_i;
  logic          rst_i;
  logic [N-1:0]  interrupt_n;
  logic          stall_x;
  logic          non_debug_exception;
  logic          debug_exception;
  logic          eret_q_x;
  logic          bret_q_x;
  logic [4:0]    csr;
  logic [31:0]   csr_write_data;
  logic          csr_write_enable;
  logic          interrupt_exception;
  logic          irq_valid;
  logic [4:0]    irq_id;
  logic [31:0]   csr_read_data;

  lm32_interrupt_vec #(.INTERRUPTS(N)) u_dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .interrupt_n         (interrupt_n),
    .stall_x             (stall_x),
    .non_debug_exception (non_debug_exception),
    .debug_exception     (debug_exception),
    .eret_q_x            (eret_q_x),
    .bret_q_x            (bret_q_x),
    .csr                 (csr),
    .csr_write_data      (csr_write_data),
    .csr_write_enable    (csr_write_enable),
    .interrupt_exception (interrupt_exception),
    .irq_valid           (irq_valid),
    .irq_id              (irq_id),
    .csr_read_data       (csr_read_data)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model state (channel vectors held as 32-bit words).
  bit          m_ie, m_eie, m_bie, m_valid;
  bit [31:0]   m_im, m_ip, m_iedge, m_prev;
  bit [4:0]    m_id;
  bit [31:0]   m_hist[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] model_read(input logic [4:0] a);
    if (a == A_IE)         return {29'd0, m_bie, m_eie, m_ie};
    else if (a == A_IM)    return m_im;
    else if (a == A_IP)    return m_ip;
    else if (a == A_IEDGE) return m_iedge;
    else if (a == A_IVEC)  return {m_valid, 26'd0, m_id};
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_ie = 0; m_eie = 0; m_bie = 0; m_valid = 0; m_id = 0;
    m_im = 0; m_ip = 0; m_iedge = 0; m_prev = 32'hFFFF_FFFF;
    m_hist.delete();
    repeat (SYNC) m_hist.push_back(32'hFFFF_FFFF);
  endtask

  // One clock of the specified behaviour, using the inputs presented this cycle.
  task automatic model_step();
    bit [31:0] pin, set, pend, clear;
    bit        found;
    if (!rst_i) begin
      model_reset();
      return;
    end
    m_hist.push_back(32'(interrupt_n));
    pin = m_hist.pop_front();
    set = 0;
    for (int i = 0; i < N; i++)
      set[i] = m_iedge[i] ? (m_prev[i] & ~pin[i]) : ~pin[i];
    m_prev = pin;
    pend    = m_ip & m_im;
    m_valid = (pend != 0);
    m_id    = 0;
    found   = 0;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && !found) begin
        m_id  = 5'(i);
        found = 1;
      end
    end
    clear = 0;
    if (non_debug_exception) begin
      m_eie = m_ie; m_ie = 0;
    end else if (debug_exception) begin
      m_bie = m_ie; m_ie = 0;
    end else if (!stall_x && eret_q_x) begin
      m_ie = m_eie;
    end else if (!stall_x && bret_q_x) begin
      m_ie = m_bie;
    end else if (!stall_x && csr_write_enable) begin
      if (csr == A_IE) begin
        m_ie = csr_write_data[0]; m_eie = csr_write_data[1]; m_bie = csr_write_data[2];
      end else if (csr == A_IM)    m_im    = csr_write_data & MASK;
      else if (csr == A_IP)        clear   = csr_write_data & MASK;
      else if (csr == A_IEDGE)     m_iedge = csr_write_data & MASK;
    end
    m_ip = ((m_ip & ~clear) | set) & MASK;
  endtask

  // Inputs are already driven; compare all outputs, then advance one clock.
  task automatic do_cycle();
    #1;
    check_val("exc", 32'(interrupt_exception), 32'(m_ie && ((m_ip & m_im) != 0)));
    check_val("irq_valid", 32'(irq_valid), 32'(m_valid));
    check_val("irq_id", 32'(irq_id), 32'(m_id));
    check_val("rdata", csr_read_data, model_read(csr));
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic idle();
    rst_i = 1; stall_x = 0; non_debug_exception = 0; debug_exception = 0;
    eret_q_x = 0; bret_q_x = 0; csr = A_IVEC; csr_write_data = 0; csr_write_enable = 0;
  endtask

  task automatic wcsr(input logic [4:0] a, input logic [31:0] d);
    csr = a; csr_write_data = d; csr_write_enable = 1;
    do_cycle();
    csr_write_enable = 0;
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    csr = a;
    #1;
    check_val(tag, csr_read_data, exp);
  endtask

  task automatic reset_dut();
    idle();
    interrupt_n = '1;
    rst_i = 0;
    do_cycle();
    rst_i = 1;
  endtask

  initial begin
    idle();
    interrupt_n = '1;
    rst_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    model_reset();

    // Reset state
    reset_dut();
    peek("rst_ivec", A_IVEC, 32'h0);
    peek("rst_ie", A_IE, 32'h0);

    // Level channel 0
    reset_dut();
    wcsr(A_IM, 32'h1);
    wcsr(A_IE, 32'h1);
    interrupt_n = ~N'(1);
    repeat (SYNC + 1) do_cycle();
    check_val("t1_exc", 32'(interrupt_exception), 32'd1);
    peek("t1_ivec_early", A_IVEC, 32'h0);
    do_cycle();
    check_val("t1_valid", 32'(irq_valid), 32'd1);
    check_val("t1_id", 32'(irq_id), 32'd0);
    peek("t1_ivec", A_IVEC, 32'h8000_0000);

    // Edge channel 2 with software clear while line held low
    reset_dut();
    wcsr(A_IEDGE, 32'h4);
    wcsr(A_IM, 32'h4);
    interrupt_n = ~N'(4);
    repeat (SYNC + 1) do_cycle();
    peek("t2_ip_set", A_IP, 32'h4);
    wcsr(A_IP, 32'h4);
    peek("t2_ip_clr", A_IP, 32'h0);
    repeat (3) do_cycle();
    peek("t2_ip_held", A_IP, 32'h0);

    // Priority
    reset_dut();
    wcsr(A_IM, 32'hF0);
    interrupt_n = ~N'(32'hA0);
    repeat (SYNC + 2) do_cycle();
    check_val("t3_id5", 32'(irq_id), 32'd5);
    wcsr(A_IM, 32'h80);
    do_cycle();
    check_val("t3_id7", 32'(irq_id), 32'd7);

    // Nesting and eret under stall
    reset_dut();
    wcsr(A_IE, 32'h1);
    non_debug_exception = 1;
    do_cycle();
    non_debug_exception = 0;
    peek("t4_exc", A_IE, 32'h2);
    eret_q_x = 1; stall_x = 1;
    do_cycle();
    peek("t4_stall", A_IE, 32'h2);
    stall_x = 0;
    do_cycle();
    eret_q_x = 0;
    peek("t4_eret", A_IE, 32'h3);

    // Write collides with debug exception
    reset_dut();
    wcsr(A_IE, 32'h1);
    csr = A_IE; csr_write_data = 0; csr_write_enable = 1; debug_exception = 1;
    do_cycle();
    csr_write_enable = 0; debug_exception = 0;
    peek("t5_ie", A_IE, 32'h4);

    // Upper bits and reset while pending
    reset_dut();
    wcsr(A_IM, 32'hFFFF_FFFF);
    peek("t6_im_mask", A_IM, MASK);
    wcsr(A_IE, 32'h1);
    interrupt_n = ~N'(32'hFF);
    repeat (SYNC + 2) do_cycle();
    peek("t6_ip", A_IP, 32'hFF);
    check_val("t6_exc_pend", 32'(interrupt_exception), 32'd1);
    rst_i = 0;
    do_cycle();
    peek("t6_ivec", A_IVEC, 32'h0);
    peek("t6_ip_rst", A_IP, 32'h0);
    check_val("t6_exc_rst", 32'(interrupt_exception), 32'd0);
    rst_i = 1;

    // Randomized traffic
    reset_dut();
    interrupt_n = '1;
    for (int n = 0; n < 3000; n++) begin
      interrupt_n         = interrupt_n ^ (N'($urandom) & N'($urandom) & N'($urandom));
      rst_i               = ($urandom_range(0, 199) != 0);
      stall_x             = ($urandom_range(0, 3) == 0);
      non_debug_exception = ($urandom_range(0, 15) == 0);
      debug_exception     = ($urandom_range(0, 15) == 0);
      eret_q_x            = ($urandom_range(0, 9) == 0);
      bret_q_x            = ($urandom_range(0, 9) == 0);
      csr_write_enable    = ($urandom_range(0, 2) == 0);
      csr_write_data      = $urandom;
      case ($urandom_range(0, 6))
        0:       csr = A_IE;
        1:       csr = A_IM;
        2, 6:    csr = A_IP;
        3:       csr = A_IEDGE;
        4:       csr = A_IVEC;
        default: csr = 5'($urandom);
      endcase
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
